mem_access_stage: RTL and testbench

Memory-access stage of the 5-stage CPU pipeline, directly downstream of the EX/MEM pipeline register. It takes the EX/MEM outputs, runs word loads and stores against a multi-cycle data-RAM bus with a request/acknowledge handshake, and selects the write-back value. It stalls the upstream pipeline while an access is outstanding and registers the result into the MEM/WB boundary.

---
 rtl/mem_access_stage_pkg.sv | 16 +
 rtl/mem_access_stage_dram_req_ctrl.sv | 74 +++++++
 rtl/mem_access_stage.sv | 99 +++++++++
 tb/tb_mem_access_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: write-back select codes and
// the bus-controller FSM states.
package mem_access_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DRAM = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_EXT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage_dram_req_ctrl.sv
// Data-RAM bus controller: request/ack handshake FSM, wait counter with
// timeout, bus-side registers and the load-data register.
module dram_req_ctrl
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output state_t      state,
    output logic [31:0] load_data,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    // FSM with registered bus outputs; an ack outside REQ is never looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dram_req    <= 1'b0;
            dram_we     <= 1'b0;
            dram_addr   <= '0;
            dram_wdata  <= '0;
            load_data   <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dram_we    <= we;
                        dram_addr  <= addr;
                        dram_wdata <= wdata;
                        wait_cnt   <= '0;
                        dram_req   <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                    if (dram_ack) begin
                        load_data <= dram_rdata;
                        dram_req  <= 1'b0;
                        state     <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // This was the last allowed REQ cycle: give up.
                        timeout_err <= 1'b1;
                        load_data   <= '0;
                        dram_req    <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: decodes loads/stores, checks alignment, stalls upstream while a
// bus access is outstanding, selects write-back data and holds MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEMDramWriteEnable,
    input  logic        MEMRegisterFileWriteEnable,
    input  logic [1:0]  MEMRegisterFileWriteSelect,
    input  logic [4:0]  MEMWriteRegister,
    input  logic [31:0] MEMPc4,
    input  logic [31:0] MEMAluResult,
    input  logic [31:0] MEMRegisterData2,
    input  logic [31:0] MEMExt,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        mem_stall,
    output logic        WBRegisterFileWriteEnable,
    output logic [4:0]  WBWriteRegister,
    output logic [31:0] WBWriteData,
    output logic        bus_timeout_err,
    output logic        misalign_err
);

    logic        access;
    logic        misaligned;
    logic        bus_access;
    state_t      state;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign access     = MEMDramWriteEnable ||
                        (MEMRegisterFileWriteEnable && MEMRegisterFileWriteSelect == WB_DRAM);
    assign misaligned = |MEMAluResult[1:0];
    // Misaligned accesses never reach the bus, so they never stall.
    assign bus_access = access && !misaligned;
    assign mem_stall  = bus_access && (state != ST_DONE);

    dram_req_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (bus_access),
        .we          (MEMDramWriteEnable),
        .addr        (MEMAluResult),
        .wdata       (MEMRegisterData2),
        .dram_ack    (dram_ack),
        .dram_rdata  (dram_rdata),
        .dram_req    (dram_req),
        .dram_we     (dram_we),
        .dram_addr   (dram_addr),
        .dram_wdata  (dram_wdata),
        .state       (state),
        .load_data   (load_data),
        .timeout_err (bus_timeout_err)
    );

    // Write-back source mux; load data only ever comes from the load register.
    always_comb begin
        wb_data = MEMAluResult;
        case (MEMRegisterFileWriteSelect)
            WB_ALU:  wb_data = MEMAluResult;
            WB_DRAM: wb_data = misaligned ? 32'd0 : load_data;
            WB_PC4:  wb_data = MEMPc4;
            WB_EXT:  wb_data = MEMExt;
            default: wb_data = MEMAluResult;
        endcase
    end

    // MEM/WB register: capture when running, insert a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WBRegisterFileWriteEnable <= 1'b0;
            WBWriteRegister           <= '0;
            WBWriteData               <= '0;
        end else if (mem_stall) begin
            WBRegisterFileWriteEnable <= 1'b0;
            WBWriteRegister           <= '0;
            WBWriteData               <= '0;
        end else begin
            WBRegisterFileWriteEnable <= MEMRegisterFileWriteEnable;
            WBWriteRegister           <= MEMWriteRegister;
            WBWriteData               <= wb_data;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      misalign_err <= 1'b0;
        else if (access && misaligned)   misalign_err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short bus timeout.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dwe = 1'b0, rfwe = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] pc4 = 32'h0000_0044, alu = 32'd0, d2 = 32'd0, ext = 32'hFFFF_FF80;
    logic        dram_req, dram_we, dram_ack = 1'b0;
    logic [31:0] dram_addr, dram_wdata, dram_rdata = 32'd0;
    logic        mem_stall, wb_en, to_err, mis_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .MEMDramWriteEnable         (dwe),
        .MEMRegisterFileWriteEnable (rfwe),
        .MEMRegisterFileWriteSelect (sel),
        .MEMWriteRegister           (rd),
        .MEMPc4                     (pc4),
        .MEMAluResult               (alu),
        .MEMRegisterData2           (d2),
        .MEMExt                     (ext),
        .dram_req                   (dram_req),
        .dram_we                    (dram_we),
        .dram_addr                  (dram_addr),
        .dram_wdata                 (dram_wdata),
        .dram_ack                   (dram_ack),
        .dram_rdata                 (dram_rdata),
        .mem_stall                  (mem_stall),
        .WBRegisterFileWriteEnable  (wb_en),
        .WBWriteRegister            (wb_reg),
        .WBWriteData                (wb_data),
        .bus_timeout_err            (to_err),
        .misalign_err               (mis_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input logic r, input logic [1:0] s,
                          input logic [4:0] d, input logic [31:0] a, input logic [31:0] v);
        dwe = w; rfwe = r; sel = s; rd = d; alu = a; d2 = v;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] r,
                            input logic [31:0] d);
        check({tag, "_en"},   {31'd0, wb_en}, {31'd0, en});
        check({tag, "_reg"},  {27'd0, wb_reg}, {27'd0, r});
        check({tag, "_data"}, wb_data, d);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req", {31'd0, dram_req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_addr", dram_addr, 32'd0);
        check_wb("rst_wb", 1'b0, 5'd0, 32'd0);
        check("rst_errs", {30'd0, to_err, mis_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // ALU op passes straight through
        set_in(1'b0, 1'b1, 2'd0, 5'd5, 32'h0000_1234, 32'h0);
        #1 check("alu_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check_wb("alu_wb", 1'b1, 5'd5, 32'h0000_1234);
        check("alu_req", {31'd0, dram_req}, 32'd0);

        // PC+4 and immediate selects
        set_in(1'b0, 1'b1, 2'd2, 5'd31, 32'h0000_0777, 32'h0);
        step();
        check_wb("pc4_wb", 1'b1, 5'd31, 32'h0000_0044);
        set_in(1'b0, 1'b1, 2'd3, 5'd2, 32'h0000_0777, 32'h0);
        step();
        check_wb("ext_wb", 1'b1, 5'd2, 32'hFFFF_FF80);

        // Load from 0x100, ack on third REQ cycle
        set_in(1'b0, 1'b1, 2'd1, 5'd7, 32'h0000_0100, 32'h0);
        #1 check("ld_idle_stall", {31'd0, mem_stall}, 32'd1);
        check("ld_idle_req", {31'd0, dram_req}, 32'd0);
        step();
        check("ld_req1_req", {31'd0, dram_req}, 32'd1);
        check("ld_req1_addr", dram_addr, 32'h0000_0100);
        check("ld_req1_we", {31'd0, dram_we}, 32'd0);
        check("ld_req1_stall", {31'd0, mem_stall}, 32'd1);
        check_wb("ld_bubble1", 1'b0, 5'd0, 32'd0);
        step();
        check("ld_req2_stall", {31'd0, mem_stall}, 32'd1);
        step();
        check("ld_req3_stall", {31'd0, mem_stall}, 32'd1);
        dram_ack = 1'b1; dram_rdata = 32'hDEAD_BEEF;
        step();
        dram_ack = 1'b0; dram_rdata = 32'h0;
        check("ld_done_stall", {31'd0, mem_stall}, 32'd0);
        check("ld_done_req", {31'd0, dram_req}, 32'd0);
        check_wb("ld_bubble4", 1'b0, 5'd0, 32'd0);
        step();
        check_wb("ld_wb", 1'b1, 5'd7, 32'hDEAD_BEEF);
        set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Store 0xCAFEF00D to 0x200, immediate ack
        set_in(1'b1, 1'b0, 2'd0, 5'd0, 32'h0000_0200, 32'hCAFE_F00D);
        #1 check("st_idle_stall", {31'd0, mem_stall}, 32'd1);
        step();
        check("st_req", {31'd0, dram_req}, 32'd1);
        check("st_we", {31'd0, dram_we}, 32'd1);
        check("st_addr", dram_addr, 32'h0000_0200);
        check("st_wdata", dram_wdata, 32'hCAFE_F00D);
        check("st_req_stall", {31'd0, mem_stall}, 32'd1);
        dram_ack = 1'b1; dram_rdata = 32'h5555_AAAA;
        #2 check("st_ack_wdata", dram_wdata, 32'hCAFE_F00D);
        step();
        dram_ack = 1'b0; dram_rdata = 32'h0;
        check("st_done_stall", {31'd0, mem_stall}, 32'd0);
        check("st_done_req", {31'd0, dram_req}, 32'd0);
        step();
        check_wb("st_wb", 1'b0, 5'd0, 32'h0000_0200);
        set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Load with no ack: timeout after 4 REQ cycles
        set_in(1'b0, 1'b1, 2'd1, 5'd9, 32'h0000_0300, 32'h0);
        step(); step(); step(); step();
        check("to_req4_req", {31'd0, dram_req}, 32'd1);
        check("to_req4_err", {31'd0, to_err}, 32'd0);
        check("to_req4_stall", {31'd0, mem_stall}, 32'd1);
        step();
        check("to_done_err", {31'd0, to_err}, 32'd1);
        check("to_done_req", {31'd0, dram_req}, 32'd0);
        check("to_done_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check_wb("to_wb", 1'b1, 5'd9, 32'd0);
        // Late ack with an ALU op in MEM
        set_in(1'b0, 1'b1, 2'd0, 5'd10, 32'h0000_00AB, 32'h0);
        dram_ack = 1'b1; dram_rdata = 32'h1111_1111;
        step();
        dram_ack = 1'b0; dram_rdata = 32'h0;
        check("late_req", {31'd0, dram_req}, 32'd0);
        check("late_stall", {31'd0, mem_stall}, 32'd0);
        check_wb("late_wb", 1'b1, 5'd10, 32'h0000_00AB);
        check("late_err_sticky", {31'd0, to_err}, 32'd1);

        // Misaligned load
        set_in(1'b0, 1'b1, 2'd1, 5'd3, 32'h0000_0102, 32'h0);
        #1 check("mis_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check("mis_req", {31'd0, dram_req}, 32'd0);
        check("mis_err", {31'd0, mis_err}, 32'd1);
        check_wb("mis_wb", 1'b1, 5'd3, 32'd0);

        // Reset during second REQ cycle
        set_in(1'b0, 1'b1, 2'd1, 5'd4, 32'h0000_0400, 32'h0);
        step(); step();
        check("rr_req2_req", {31'd0, dram_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_req", {31'd0, dram_req}, 32'd0);
        check("rr_addr", dram_addr, 32'd0);
        check("rr_errs", {30'd0, to_err, mis_err}, 32'd0);
        check_wb("rr_wb", 1'b0, 5'd0, 32'd0);
        set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        step();
        check("rr_idle_stall", {31'd0, mem_stall}, 32'd0);
        set_in(1'b0, 1'b1, 2'd1, 5'd6, 32'h0000_0500, 32'h0);
        step();
        check("rr_new_req", {31'd0, dram_req}, 32'd1);
        check("rr_new_addr", dram_addr, 32'h0000_0500);
        dram_ack = 1'b1; dram_rdata = 32'h1234_5678;
        step();
        dram_ack = 1'b0; dram_rdata = 32'h0;
        check("rr_new_done_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check_wb("rr_new_wb", 1'b1, 5'd6, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
